// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : opcode map, handshake FSM states and helpers for seq_alu
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NAND = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_REM  = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_muldiv.sv
// ============================================================================
// seq_muldiv : iterative shift-add multiplier / restoring divider, one adder
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic             r_busy;
    logic             r_is_div;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_hi;      // product high half / partial remainder
    logic [WIDTH-1:0] r_lo;      // multiplier bits / quotient (shifts in from the right)
    logic [WIDTH-1:0] r_opnd;    // multiplicand / divisor

    logic [WIDTH:0]   w_add_x;
    logic [WIDTH:0]   w_add_y;
    logic [WIDTH+1:0] w_sum;
    logic [WIDTH:0]   w_mul_s;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // Divide reuses the adder as x + ~d + 1; its top carry means "no borrow".
    assign w_add_x = r_is_div ? {r_hi, r_lo[WIDTH-1]} : {1'b0, r_hi};
    assign w_add_y = r_is_div ? ~{1'b0, r_opnd} : {1'b0, r_opnd};
    assign w_sum   = {1'b0, w_add_x} + {1'b0, w_add_y} + {{(WIDTH+1){1'b0}}, r_is_div};

    always_comb begin
        w_mul_s  = r_lo[0] ? w_sum[WIDTH:0] : {1'b0, r_hi};
        w_hi_nxt = w_mul_s[WIDTH:1];
        w_lo_nxt = {w_mul_s[0], r_lo[WIDTH-1:1]};
        if (r_is_div) begin
            if (w_sum[WIDTH+1]) begin
                w_hi_nxt = w_sum[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_add_x[WIDTH-1:0];
                w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_is_div <= 1'b0;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_is_div <= is_div;
            r_count  <= '0;
            r_hi     <= '0;
            r_lo     <= is_div ? a : b;
            r_opnd   <= is_div ? b : a;
        end else if (r_busy) begin
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_count <= r_count + CNT_W'(1);
            if (r_count == c_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Final values are presented combinationally during the last iteration cycle.
    assign done = r_busy && (r_count == c_LAST);
    assign hi   = w_hi_nxt;
    assign lo   = w_lo_nxt;

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
// seq_alu : handshaked ALU, single-cycle add/sub/logic, iterative mul/div/rem
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op_code,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_op;
    logic             w_accept;
    logic             w_go_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH:0]   w_add_u;
    logic [WIDTH:0]   w_sub_u;
    logic [WIDTH-1:0] w_sc_res;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_cout;
    logic             w_sc_ovf;
    logic             w_sc_dbz;
    logic             w_sc_ill;
    logic             w_ld;
    logic [WIDTH-1:0] w_ld_res;
    logic [WIDTH-1:0] w_ld_hi;

    assign in_ready  = !rst && ((r_state == IDLE) || ((r_state == DONE) && out_ready));
    assign out_valid = (r_state == DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_go_busy = is_multicycle(op_code) && (b != '0);

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (w_accept && w_go_busy),
        .is_div (op_code != OP_MUL),
        .a      (a),
        .b      (b),
        .done   (w_md_done),
        .hi     (w_md_hi),
        .lo     (w_md_lo)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_nxt = w_go_busy ? BUSY : DONE;
            BUSY: if (w_md_done) w_state_nxt = DONE;
            DONE: begin
                if (w_accept)       w_state_nxt = w_go_busy ? BUSY : DONE;
                else if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_op    <= OP_ADD;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_op <= op_code;
        end
    end

    assign w_add_u = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign w_sub_u = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, carry_in};

    // Signed overflow from operand and result signs; exact with carry/borrow-in.
    always_comb begin
        w_sc_res  = '0;
        w_sc_hi   = '0;
        w_sc_cout = 1'b0;
        w_sc_ovf  = 1'b0;
        w_sc_dbz  = 1'b0;
        w_sc_ill  = 1'b0;
        case (op_code)
            OP_ADD: begin
                w_sc_res  = w_add_u[WIDTH-1:0];
                w_sc_cout = w_add_u[WIDTH];
                w_sc_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (w_add_u[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_res  = w_sub_u[WIDTH-1:0];
                w_sc_cout = w_sub_u[WIDTH];
                w_sc_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub_u[WIDTH-1] != a[WIDTH-1]);
            end
            OP_MUL:  w_sc_res = '0;
            OP_DIV: begin
                w_sc_res = '1;
                w_sc_hi  = a;
                w_sc_dbz = 1'b1;
            end
            OP_REM: begin
                w_sc_res = a;
                w_sc_hi  = '1;
                w_sc_dbz = 1'b1;
            end
            OP_AND:  w_sc_res = a & b;
            OP_OR:   w_sc_res = a | b;
            OP_XOR:  w_sc_res = a ^ b;
            OP_NAND: w_sc_res = ~(a & b);
            OP_NOR:  w_sc_res = ~(a | b);
            OP_XNOR: w_sc_res = ~(a ^ b);
            default: w_sc_ill = 1'b1;
        endcase
    end

    // The engine reports {hi,lo} as product, or {remainder,quotient} for divide.
    always_comb begin
        w_ld     = (w_accept && !w_go_busy) || w_md_done;
        w_ld_res = w_sc_res;
        w_ld_hi  = w_sc_hi;
        if (w_md_done) begin
            case (r_op)
                OP_MUL: begin w_ld_res = w_md_lo; w_ld_hi = w_md_hi; end
                OP_REM: begin w_ld_res = w_md_hi; w_ld_hi = w_md_lo; end
                default: begin w_ld_res = w_md_lo; w_ld_hi = w_md_hi; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result      <= '0;
            result_hi   <= '0;
            carry_out   <= 1'b0;
            overflow    <= 1'b0;
            zero        <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (w_ld) begin
            result      <= w_ld_res;
            result_hi   <= w_ld_hi;
            carry_out   <= w_md_done ? 1'b0 : w_sc_cout;
            overflow    <= w_md_done ? 1'b0 : w_sc_ovf;
            zero        <= (w_ld_res == '0);
            div_by_zero <= w_md_done ? 1'b0 : w_sc_dbz;
            illegal_op  <= w_md_done ? 1'b0 : w_sc_ill;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
// tb_seq_alu : directed self-checking bench for seq_alu (WIDTH = 8)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op_code;
    logic       carry_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [7:0] result_hi;
    logic       carry_out;
    logic       overflow;
    logic       zero;
    logic       div_by_zero;
    logic       illegal_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op_code     (op_code),
        .carry_in    (carry_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_hi   (result_hi),
        .carry_out   (carry_out),
        .overflow    (overflow),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // flags order: {carry_out, overflow, zero, div_by_zero, illegal_op}
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] va,
                          input logic [7:0] vb, input logic vcin, input logic [7:0] er,
                          input logic [7:0] eh, input logic [4:0] ef, input int elat);
        int lat;
        out_ready = 1'b0;
        check({tag, ".rdy"}, in_ready, 1);
        in_valid = 1'b1; op_code = op; a = va; b = vb; carry_in = vcin;
        tick();
        in_valid = 1'b0; op_code = 4'h6; a = 8'hA5; b = 8'h3C; carry_in = 1'b1;
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (lat == 4) check({tag, ".busy_rdy"}, in_ready, 0);
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, elat);
        check({tag, ".res"}, result, er);
        check({tag, ".hi"}, result_hi, eh);
        check({tag, ".flags"}, {carry_out, overflow, zero, div_by_zero, illegal_op}, ef);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".drain"}, out_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; op_code = '0; carry_in = 1'b0;
        tick();
        tick();
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.outs", {result, result_hi, carry_out, overflow, zero, div_by_zero, illegal_op}, 0);
        rst = 1'b0;
        #1;
        check("rst.release_rdy", in_ready, 1);

        run_op("add_wrap",  4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h00, 5'b10100, 1);
        run_op("add_ovf",   4'h0, 8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 5'b01000, 1);
        run_op("sub_ovf",   4'h1, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h00, 5'b01000, 1);
        run_op("sub_borrow",4'h1, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h00, 5'b10000, 1);
        run_op("sub_cin",   4'h1, 8'h05, 8'h03, 1'b1, 8'h01, 8'h00, 5'b00000, 1);
        run_op("mul_ff",    4'h2, 8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 5'b00000, 9);
        run_op("mul_small", 4'h2, 8'h0D, 8'h0B, 1'b0, 8'h8F, 8'h00, 5'b00000, 9);
        run_op("div",       4'h3, 8'd100, 8'd7, 1'b0, 8'd14, 8'd2,  5'b00000, 9);
        run_op("rem",       4'hA, 8'd100, 8'd7, 1'b0, 8'd2,  8'd14, 5'b00000, 9);
        run_op("div_small", 4'h3, 8'd5,   8'd9, 1'b0, 8'd0,  8'd5,  5'b00100, 9);
        run_op("div_zero",  4'h3, 8'h35, 8'h00, 1'b0, 8'hFF, 8'h35, 5'b00010, 1);
        run_op("rem_zero",  4'hA, 8'h35, 8'h00, 1'b0, 8'h35, 8'hFF, 5'b00010, 1);
        run_op("or",        4'h5, 8'hA0, 8'h05, 1'b0, 8'hA5, 8'h00, 5'b00000, 1);
        run_op("nand",      4'h7, 8'hF0, 8'h3C, 1'b0, 8'hCF, 8'h00, 5'b00000, 1);
        run_op("nor",       4'h8, 8'h0F, 8'h30, 1'b0, 8'hC0, 8'h00, 5'b00000, 1);
        run_op("xnor",      4'h9, 8'hFF, 8'h0F, 1'b0, 8'h0F, 8'h00, 5'b00000, 1);
        run_op("illegal_b", 4'hB, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 5'b00101, 1);

        // Backpressure: XOR result must hold while the consumer stalls.
        out_ready = 1'b0;
        in_valid = 1'b1; op_code = 4'h6; a = 8'h5A; b = 8'h0F; carry_in = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp.valid", out_valid, 1);
            check("bp.res", result, 8'h55);
            check("bp.rdy", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b1; op_code = 4'h4; a = 8'hF0; b = 8'h3C;
        #1;
        check("handoff.rdy", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("handoff.valid", out_valid, 1);
        check("handoff.res", result, 8'h30);
        check("handoff.zero", zero, 0);
        tick();
        check("handoff.drain", out_valid, 0);
        out_ready = 1'b0;

        // Reset in the fourth BUSY cycle of a multiply aborts it.
        in_valid = 1'b1; op_code = 4'h2; a = 8'hFF; b = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("abort.rst_rdy", in_ready, 0);
        tick();
        rst = 1'b0;
        check("abort.valid", out_valid, 0);
        check("abort.outs", {result, result_hi, carry_out, overflow, zero, div_by_zero, illegal_op}, 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("abort.no_valid", seen, 0);
        run_op("illegal_c", 4'hC, 8'h77, 8'h11, 1'b1, 8'h00, 8'h00, 5'b00101, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the team's 4-bit combinational ALU. It keeps the same 4-bit opcode map and generalises operand width. Add, subtract and logic ops complete in one cycle; multiply and divide run on an iterative shift/subtract engine over WIDTH cycles. The block sits between the register-read stage and write-back, behind a valid/ready handshake on both sides, and holds one operation in flight at a time.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request this cycle
- a  in  WIDTH  operand A (numerator for divide)
- b  in  WIDTH  operand B (denominator for divide)
- op_code  in  4  operation select
- carry_in  in  1  carry/borrow input for add/sub
- out_valid  out  1  result registers hold a completed operation
- out_ready  in  1  consumer accepts the result
- result  out  WIDTH  primary result
- result_hi  out  WIDTH  multiply high half / secondary divide output, else 0
- carry_out  out  1  add carry / sub borrow, else 0
- overflow  out  1  signed overflow for add/sub, else 0
- zero  out  1  result == 0
- div_by_zero  out  1  divide requested with b == 0
- illegal_op  out  1  op_code 0xB–0xF

## Operation
- Opcodes:
  - 0x0 add: {carry_out,result} = a+b+carry_in
  - 0x1 sub: result = a−b−carry_in; carry_out = 1 on borrow
  - 0x2 mul: {result_hi,result} = a*b, unsigned, 2·WIDTH bits
  - 0x3 div: result = quotient, result_hi = remainder, unsigned
  - 0x4 AND, 0x5 OR, 0x6 XOR, 0x7 NAND, 0x8 NOR, 0x9 XNOR
  - 0xA rem: result = remainder, result_hi = quotient
  - 0xB–0xF: result = 0, illegal_op = 1
- overflow: two's-complement overflow of the add/sub result; 0 for all other ops.
- Operands, op_code and carry_in are captured on accept (in_valid && in_ready). Changes while busy are ignored.
- States:
  - IDLE → DONE on accept of a single-cycle op, an illegal op, or a divide with b == 0
  - IDLE → BUSY on accept of mul/div/rem with b ≠ 0
  - BUSY → DONE when the iteration counter reaches WIDTH−1
  - DONE → IDLE when out_ready and no new accept
  - DONE → DONE/BUSY on a same-cycle handoff
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is combinational in out_ready, so a new op can be accepted in the same cycle the old result is taken.
- Divide by zero: result = all ones, result_hi = a, div_by_zero = 1, no BUSY cycles. Op 0xA swaps the two outputs.
- Result and flag outputs are registered and stable while out_valid && !out_ready. They update only on completion.
- Reset:
  - all outputs 0, in_ready = 0 during the reset cycle, state IDLE, counter 0
  - reset during BUSY aborts the operation with no out_valid
  - in_ready = 1 the cycle after rst deasserts

## Timing
- Single-cycle ops: accept at edge E, out_valid = 1 after E. Latency 1, throughput 1/cycle with out_ready held high.
- mul/div/rem (b ≠ 0): accept at E, BUSY for WIDTH cycles, out_valid = 1 after edge E+WIDTH. Latency WIDTH+1, in_ready = 0 throughout BUSY.
- Backpressure: out_valid holds until out_ready; no result is dropped or overwritten.
- Flags (zero, carry_out, overflow, div_by_zero, illegal_op) are valid only while out_valid = 1.

## Structure
- alu_pkg holds:
  - opcode localparams (OP_ADD…OP_REM)
  - state enum (IDLE, BUSY, DONE)
  - is_multicycle(op) function
- One sub-module, seq_muldiv:
  - iterative unsigned shift-add multiplier and restoring divider sharing one WIDTH-bit adder and counter
  - start/done interface, parametrised by WIDTH
- Top level holds the handshake FSM, the single-cycle datapath and the output registers.

## Test plan
- WIDTH=8, add a=0xFF b=0x01 cin=0 → result 0x00, carry_out 1, zero 1, overflow 0, out_valid one cycle after accept.
- Sub a=0x80 b=0x01 cin=0 → result 0x7F, carry_out 0, overflow 1. Sub a=0x00 b=0x01 → 0xFF, carry_out 1.
- Mul a=0xFF b=0xFF → result 0x01, result_hi 0xFE. out_valid exactly 9 cycles after accept, in_ready 0 while BUSY.
- Div a=100 b=7 → result 14, result_hi 2. Op 0xA → result 2, result_hi 14. Div a=0x35 b=0 → result 0xFF, result_hi 0x35, div_by_zero 1, latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after an XOR completes → outputs stable, in_ready 0. Raise out_ready together with a new AND request → same-cycle handoff, AND result next cycle.
- Assert rst in BUSY cycle 4 of a multiply → no out_valid, all outputs 0. Op 0xC afterwards → result 0, illegal_op 1.
